// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and parameter helpers.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step configuration still keeps a 1-bit counter so ports/regs never go zero-width.
  function automatic int calc_cnt_w(input int width, input int digit);
    int steps;
    steps = width / digit;
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// DIGIT-bit combinational ripple of full-adder bits; also exposes the carry into the
// slice MSB so the parent can derive two's-complement overflow.
module fa_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, LSB digit first, with valid/ready on both sides.
//   state   | meaning
//   ST_IDLE | ready for operands
//   ST_RUN  | one digit per cycle through fa_slice, carry held in carry_q
//   ST_DONE | result, cout and ovf presented until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] step_q, step_d;

  logic [DIGIT-1:0] b_dig, dig_sum;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] dig_sum_ext;

  // Operands shift right each step, so the active digit is always the low DIGIT bits.
  assign b_dig       = sub_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
  assign dig_sum_ext = WIDTH'(dig_sum) << (WIDTH - DIGIT);

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_dig),
    .c_i     (carry_q),
    .s_o     (dig_sum),
    .c_o     (dig_cout),
    .c_msb_o (dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? ~cin : cin;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        sum_d   = (sum_q >> DIGIT) | dig_sum_ext;
        if (step_q == LAST_STEP) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      step_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed and random ops on a 16/4 instance plus
// random sweeps on other WIDTH/DIGIT configurations against an arithmetic reference.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int sweep_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, expv);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic sb);
    exp_t e;
    longint m, half, ua, ub, sa, sbv, c, ut, t;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    c    = ci ? 1 : 0;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sbv  = (ub >= half) ? ub - (m + 1) : ub;
    if (!sb) begin
      ut     = ua + ub + c;
      e.cout = (ut > m);
      t      = sa + sbv + c;
    end else begin
      ut     = ua - ub - c;
      e.cout = (ua >= ub + c);
      t      = sa - sbv - c;
    end
    e.sum = 16'(ut & m);
    e.ovf = (t >= half) || (t < -half);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov; e.acc = 0;
    return e;
  endfunction

  // ---------------- main 16/4 instance ----------------
  localparam int STEPS_MAIN = 4;
  logic        rst = 1'b1, in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b0, cout, ovf;
  logic [15:0] a = '0, b = '0, sum;
  exp_t        exp_q[$];
  bit          rdy_rand = 1'b0;
  bit          rdy_val = 1'b1;
  int          last_hs = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial forever begin
    @(posedge clk); #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  initial begin : main_mon
    bit   ovp;
    int   rise;
    exp_t e;
    ovp = 1'b0; rise = 0;
    forever begin
      @(negedge clk);
      if (rst) ovp = 1'b0;
      else begin
        if (out_valid && !ovp) rise = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", cout, e.cout);
            chk("ovf", ovf, e.ovf);
            chk("latency", rise - e.acc, STEPS_MAIN);
          end
          last_hs = cyc + 1;
        end
        ovp = out_valid;
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                      input logic sb, input exp_t e, input bit keep, output int acc);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc; e.acc = cyc;
        exp_q.push_back(e);
        break;
      end
    end
    if (!keep) in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_empty(input string nm);
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin : main_drv
    int acc0, acc1, acc2, bad;
    logic [15:0] ra, rb;
    logic rc, rs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1; rst = 1'b0;

    send(16'h1234, 16'h0FFF, 0, 0, mk(16'h2233, 0, 0), 0, acc0);  wait_empty("drain_basic");
    send(16'hFFFF, 16'h0001, 0, 0, mk(16'h0000, 1, 0), 0, acc0);  wait_empty("drain_carry");
    send(16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1), 0, acc0);  wait_empty("drain_ovf");
    send(16'h0005, 16'h0007, 0, 1, mk(16'hFFFE, 0, 0), 0, acc0);  wait_empty("drain_sub");
    send(16'h8000, 16'h0001, 0, 1, mk(16'h7FFF, 1, 1), 0, acc0);  wait_empty("drain_sub_ovf");

    // backpressure: result must sit untouched while out_ready is low
    rdy_val = 1'b0;
    send(16'h1111, 16'h2222, 0, 0, mk(16'h3333, 0, 0), 0, acc0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, 16'h3333);
      chk("bp_cout", cout, 0);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    wait_empty("drain_bp");

    // operands scrambled right after acceptance
    send(16'h00F0, 16'h0F0F, 0, 0, mk(16'h0FFF, 0, 0), 0, acc0);
    a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b1;
    wait_empty("drain_isolation");

    // in_valid held high: accept exactly one cycle after each output handshake
    send(16'hAAAA, 16'h5555, 1, 0, mk(16'h0000, 1, 0), 1, acc0);
    send(16'h4000, 16'h4000, 0, 0, mk(16'h8000, 0, 1), 1, acc1);
    chk("stream_spacing1", acc1 - acc0, STEPS_MAIN + 2);
    chk("stream_after_hs1", acc1, last_hs + 1);
    send(16'h0000, 16'h0000, 1, 1, mk(16'hFFFF, 0, 0), 0, acc2);
    chk("stream_spacing2", acc2 - acc1, STEPS_MAIN + 2);
    chk("stream_after_hs2", acc2, last_hs + 1);
    wait_empty("drain_stream");

    // reset while RUN is on step 2
    send(16'h1234, 16'h1111, 0, 0, mk(16'h2345, 0, 0), 0, acc0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) bad = 1;
      @(negedge clk);
    end
    chk("abort_no_stray", bad, 0);
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 0, 0, mk(16'h0002, 0, 0), 0, acc0);  wait_empty("drain_fresh");

    // random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(16, ra, rb, rc, rs), 0, acc0);
    end
    rdy_rand = 1'b0;
    wait_empty("drain_random");

    for (int k = 0; k < 20000; k++) begin
      if (sweep_done == 4) break;
      @(posedge clk);
    end
    chk("sweep_completion", sweep_done, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  localparam int SW[4] = '{16, 16, 16, 8};
  localparam int SD[4] = '{1, 2, 16, 8};

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = SW[g];
    localparam int D = SD[g];
    localparam int ST = W / D;

    logic         rst_l = 1'b1, in_valid_l = 1'b0, in_ready_l, cin_l = 1'b0, sub_l = 1'b0;
    logic         out_valid_l, out_ready_l = 1'b0, cout_l, ovf_l;
    logic [W-1:0] a_l = '0, b_l = '0, sum_l;
    exp_t         q[$];

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst_l), .in_valid(in_valid_l), .in_ready(in_ready_l), .a(a_l), .b(b_l),
      .cin(cin_l), .sub(sub_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
      .sum(sum_l), .cout(cout_l), .ovf(ovf_l)
    );

    initial forever begin
      @(posedge clk); #2;
      out_ready_l = 1'($urandom_range(0, 1));
    end

    initial begin : mon
      bit   ovp;
      int   rise;
      exp_t e;
      ovp = 1'b0; rise = 0;
      forever begin
        @(negedge clk);
        if (rst_l) ovp = 1'b0;
        else begin
          if (out_valid_l && !ovp) rise = cyc;
          if (out_valid_l && out_ready_l) begin
            if (q.size() == 0) chk($sformatf("sweep%0d_spurious", g), 1, 0);
            else begin
              e = q.pop_front();
              chk($sformatf("sweep%0d_sum", g), sum_l, e.sum[W-1:0]);
              chk($sformatf("sweep%0d_cout", g), cout_l, e.cout);
              chk($sformatf("sweep%0d_ovf", g), ovf_l, e.ovf);
              chk($sformatf("sweep%0d_latency", g), rise - e.acc, ST);
            end
          end
          ovp = out_valid_l;
        end
      end
    end

    initial begin : drv
      exp_t e;
      int   acc;
      repeat (3) @(posedge clk);
      #1; rst_l = 1'b0;
      for (int n = 0; n < 25; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        a_l = W'($urandom); b_l = W'($urandom);
        cin_l = 1'($urandom_range(0, 1)); sub_l = 1'($urandom_range(0, 1));
        e = model(W, 16'(a_l), 16'(b_l), cin_l, sub_l);
        in_valid_l = 1'b1;
        acc = -1;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (in_ready_l) begin
            @(posedge clk); #1;
            acc = cyc; e.acc = cyc;
            q.push_back(e);
            break;
          end
        end
        in_valid_l = 1'b0;
        if (acc < 0) chk($sformatf("sweep%0d_accept_timeout", g), 0, 1);
      end
      for (int k = 0; k < 400; k++) begin
        if (q.size() == 0) break;
        @(negedge clk);
      end
      chk($sformatf("sweep%0d_drain", g), q.size(), 0);
      sweep_done++;
    end
  end

endmodule
